// File: rtl/pipe_pkg.sv
// Shared definitions for generic pipeline stage registers: state encoding
// (which doubles as the occupancy count) and a default NOP payload.
package pipe_pkg;

    typedef logic [1:0] state_t;

    // The encoding equals the number of entries held, so occupancy is the state itself.
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_FULL  = 2'd1;
    localparam state_t ST_SKID  = 2'd2;

    // Default NOP for 32-bit instruction payloads (addi x0, x0, 0).
    localparam int                   NOP_WIDTH  = 32;
    localparam logic [NOP_WIDTH-1:0] NOP_BUBBLE = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: WIDTH-bit payload with valid/ready handshake,
// synchronous flush-to-bubble and an optional skid entry that registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // in_ready decodes registered state only, breaking the out_ready -> in_ready path.
            assign in_ready = (state_q != ST_SKID);

            always_ff @(posedge CLK or negedge Reset_n) begin
                if (!Reset_n) begin
                    skid_q <= BUBBLE;
                end else if (flush) begin
                    skid_q <= BUBBLE;
                end else if (state_q == ST_FULL && in_fire && !out_fire) begin
                    skid_q <= in_data;
                end else if (state_q == ST_SKID && out_fire) begin
                    skid_q <= BUBBLE;
                end
            end
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
            assign skid_q   = BUBBLE;
        end
    endgenerate

    // NOTE: state and payload use non-blocking assignments so every branch reads
    // the pre-edge values of state_q/main_q/skid_q, matching the hardware.
    // NOTE: payload registers are reset (not left undefined) so an aborted
    // transfer never leaves a stale payload visible on out_data.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_q <= ST_FULL;
                        main_q  <= in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire && SKID != 0) begin
                        state_q <= ST_SKID;
                    end else if (out_fire) begin
                        state_q <= ST_EMPTY;
                        main_q  <= BUBBLE;
                    end
                end
                ST_SKID: begin
                    // Older entry leaves first; the skid entry moves up to main.
                    if (out_fire) begin
                        state_q <= ST_FULL;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    main_q  <= BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and model-checked bench for pipe_stage_reg, one instance per SKID setting.
module tb_pipe_stage_reg;

    localparam int             W   = 32;
    localparam logic [W-1:0]   BUB = 32'h0000_0013;

    logic         CLK;
    logic         Reset_n;

    logic         f1, iv1, ir1, ov1, or1;
    logic [W-1:0] id1, od1;
    logic [1:0]   occ1;

    logic         f0, iv0, ir0, ov0, or0;
    logic [W-1:0] id0, od0;
    logic [1:0]   occ0;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .BUBBLE(BUB)) dut_s1 (
        .CLK(CLK), .Reset_n(Reset_n), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .BUBBLE(BUB)) dut_s0 (
        .CLK(CLK), .Reset_n(Reset_n), .flush(f0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(occ0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Outputs are sampled 1-2 time units after the rising edge, never on it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        f1 = 0; iv1 = 0; id1 = '0; or1 = 0;
        f0 = 0; iv0 = 0; id0 = '0; or0 = 0;
    endtask

    task automatic test_reset();
        idle();
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #2;
        n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s1 got=%b exp=0", ov1); end
        n_checks++; if (od1 !== BUB)  begin n_fail++; $display("FAIL reset_data_s1 got=%h exp=%h", od1, BUB); end
        n_checks++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL reset_occ_s1 got=%0d exp=0", occ1); end
        n_checks++; if (od0 !== BUB)  begin n_fail++; $display("FAIL reset_data_s0 got=%h exp=%h", od0, BUB); end
        @(negedge CLK);
        Reset_n = 1'b1;
        tick();
        n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s1 got=%b exp=1", ir1); end
        n_checks++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s0 got=%b exp=1", ir0); end
        n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s0 got=%b exp=0", ov0); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            iv1 = 1; id1 = W'(i); or1 = 1;
            iv0 = 1; id0 = W'(i); or0 = 1;
            tick();
            n_checks++; if (ov1 !== 1'b1 || od1 !== W'(i)) begin n_fail++; $display("FAIL stream_s1 word=%0d got=%b/%h exp=1/%h", i, ov1, od1, W'(i)); end
            n_checks++; if (occ1 !== 2'd1) begin n_fail++; $display("FAIL stream_occ_s1 word=%0d got=%0d exp=1", i, occ1); end
            n_checks++; if (ov0 !== 1'b1 || od0 !== W'(i)) begin n_fail++; $display("FAIL stream_s0 word=%0d got=%b/%h exp=1/%h", i, ov0, od0, W'(i)); end
            n_checks++; if (occ0 !== 2'd1) begin n_fail++; $display("FAIL stream_occ_s0 word=%0d got=%0d exp=1", i, occ0); end
        end
        iv1 = 0; iv0 = 0;
        tick();
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB || occ1 !== 2'd0) begin n_fail++; $display("FAIL stream_drain_s1 got=%b/%h/%0d exp=0/%h/0", ov1, od1, occ1, BUB); end
        n_checks++; if (ov0 !== 1'b0 || od0 !== BUB || occ0 !== 2'd0) begin n_fail++; $display("FAIL stream_drain_s0 got=%b/%h/%0d exp=0/%h/0", ov0, od0, occ0, BUB); end
    endtask

    task automatic test_skid();
        idle();
        iv1 = 1; id1 = 32'hA; or1 = 0;
        tick();
        n_checks++; if (occ1 !== 2'd1 || od1 !== 32'hA) begin n_fail++; $display("FAIL skid_load occ=%0d data=%h exp=1/%h", occ1, od1, 32'hA); end
        id1 = 32'hB;
        settle();
        n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL skid_ready_full got=%b exp=1", ir1); end
        tick();
        iv1 = 0;
        n_checks++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL skid_occ got=%0d exp=2", occ1); end
        n_checks++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL skid_ready got=%b exp=0", ir1); end
        n_checks++; if (ov1 !== 1'b1 || od1 !== 32'hA) begin n_fail++; $display("FAIL skid_head got=%b/%h exp=1/%h", ov1, od1, 32'hA); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (od1 !== 32'hA || occ1 !== 2'd2) begin n_fail++; $display("FAIL skid_hold cyc=%0d got=%h/%0d exp=%h/2", i, od1, occ1, 32'hA); end
        end
        or1 = 1;
        settle();
        n_checks++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL skid_ready_comb got=%b exp=0", ir1); end
        tick();
        n_checks++; if (ov1 !== 1'b1 || od1 !== 32'hB || occ1 !== 2'd1) begin n_fail++; $display("FAIL skid_second got=%b/%h/%0d exp=1/%h/1", ov1, od1, occ1, 32'hB); end
        tick();
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB || occ1 !== 2'd0) begin n_fail++; $display("FAIL skid_empty got=%b/%h/%0d exp=0/%h/0", ov1, od1, occ1, BUB); end
        idle();
    endtask

    task automatic test_flush();
        idle();
        iv1 = 1; id1 = 32'hA;
        tick();
        id1 = 32'hB;
        tick();
        n_checks++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got=%0d exp=2", occ1); end
        f1 = 1; id1 = 32'hC;
        settle();
        n_checks++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL flush_ready_skid got=%b exp=0", ir1); end
        tick();
        f1 = 0; iv1 = 0; or1 = 1;
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB || occ1 !== 2'd0) begin n_fail++; $display("FAIL flush_skid got=%b/%h/%0d exp=0/%h/0", ov1, od1, occ1, BUB); end
        n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after got=%b exp=1", ir1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (ov1 !== 1'b0 || od1 !== BUB) begin n_fail++; $display("FAIL flush_no_leak cyc=%0d got=%b/%h exp=0/%h", i, ov1, od1, BUB); end
        end
        f1 = 1; iv1 = 1; id1 = 32'hD;
        settle();
        n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL flush_ready_empty got=%b exp=1", ir1); end
        tick();
        n_checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL flush_empty_in got=%b/%0d exp=0/0", ov1, occ1); end
        f1 = 0; id1 = 32'hE;
        tick();
        n_checks++; if (ov1 !== 1'b1 || od1 !== 32'hE) begin n_fail++; $display("FAIL flush_reload got=%b/%h exp=1/%h", ov1, od1, 32'hE); end
        f1 = 1; id1 = 32'hF;
        tick();
        f1 = 0; iv1 = 0;
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB) begin n_fail++; $display("FAIL flush_full_fire got=%b/%h exp=0/%h", ov1, od1, BUB); end
        tick();
        n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL flush_discard got=%b exp=0", ov1); end
        idle();
    endtask

    task automatic test_noskid();
        idle();
        iv0 = 1; id0 = 32'h5; or0 = 0;
        settle();
        n_checks++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL ns_ready_empty got=%b exp=1", ir0); end
        tick();
        n_checks++; if (ov0 !== 1'b1 || od0 !== 32'h5) begin n_fail++; $display("FAIL ns_load got=%b/%h exp=1/%h", ov0, od0, 32'h5); end
        id0 = 32'h6;
        settle();
        n_checks++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL ns_ready_stall got=%b exp=0", ir0); end
        tick();
        n_checks++; if (od0 !== 32'h5 || occ0 !== 2'd1) begin n_fail++; $display("FAIL ns_hold got=%h/%0d exp=%h/1", od0, occ0, 32'h5); end
        or0 = 1;
        settle();
        n_checks++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL ns_ready_go got=%b exp=1", ir0); end
        tick();
        n_checks++; if (od0 !== 32'h6 || occ0 !== 2'd1) begin n_fail++; $display("FAIL ns_next got=%h/%0d exp=%h/1", od0, occ0, 32'h6); end
        or0 = 0; id0 = 32'h7;
        settle();
        n_checks++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL ns_ready_stall2 got=%b exp=0", ir0); end
        tick();
        n_checks++; if (od0 !== 32'h6) begin n_fail++; $display("FAIL ns_hold2 got=%h exp=%h", od0, 32'h6); end
        or0 = 1;
        tick();
        n_checks++; if (od0 !== 32'h7) begin n_fail++; $display("FAIL ns_third got=%h exp=%h", od0, 32'h7); end
        iv0 = 0;
        tick();
        n_checks++; if (ov0 !== 1'b0 || od0 !== BUB || occ0 !== 2'd0) begin n_fail++; $display("FAIL ns_empty got=%b/%h/%0d exp=0/%h/0", ov0, od0, occ0, BUB); end
        idle();
    endtask

    task automatic test_random();
        logic [W-1:0] q1[$];
        logic [W-1:0] q0[$];
        logic         eir1, eir0, in1, out1, in0, out0;
        idle();
        or1 = 1; or0 = 1;
        repeat (3) tick();
        for (int c = 0; c < 10000; c++) begin
            iv1 = 1'($urandom_range(0, 1)); id1 = $urandom; or1 = 1'($urandom_range(0, 1));
            iv0 = 1'($urandom_range(0, 1)); id0 = $urandom; or0 = 1'($urandom_range(0, 1));
            settle();
            eir1 = (q1.size() < 2);
            eir0 = (q0.size() == 0) || or0;
            n_checks++; if (ov1 !== (q1.size() > 0) || od1 !== ((q1.size() > 0) ? q1[0] : BUB) || occ1 !== 2'(q1.size()) || ir1 !== eir1) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rnd_s1 cyc=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", c, ov1, od1, occ1, ir1, (q1.size() > 0), (q1.size() > 0) ? q1[0] : BUB, q1.size(), eir1);
            end
            n_checks++; if (ov0 !== (q0.size() > 0) || od0 !== ((q0.size() > 0) ? q0[0] : BUB) || occ0 !== 2'(q0.size()) || ir0 !== eir0) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rnd_s0 cyc=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", c, ov0, od0, occ0, ir0, (q0.size() > 0), (q0.size() > 0) ? q0[0] : BUB, q0.size(), eir0);
            end
            in1 = iv1 & eir1; out1 = (q1.size() > 0) & or1;
            in0 = iv0 & eir0; out0 = (q0.size() > 0) & or0;
            if (out1) void'(q1.pop_front());
            if (in1) q1.push_back(id1);
            if (out0) void'(q0.pop_front());
            if (in0) q0.push_back(id0);
            tick();
        end
        idle();
        or1 = 1; or0 = 1;
        repeat (3) tick();
        n_checks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got=%b/%b exp=0/0", ov1, ov0); end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        iv1 = 1; id1 = 32'hA;
        iv0 = 1; id0 = 32'h5;
        tick();
        id1 = 32'hB; iv0 = 0;
        tick();
        iv1 = 0;
        n_checks++; if (occ1 !== 2'd2 || occ0 !== 2'd1) begin n_fail++; $display("FAIL arst_pre got=%0d/%0d exp=2/1", occ1, occ0); end
        #2 Reset_n = 1'b0;
        #1;
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB || occ1 !== 2'd0 || ir1 !== 1'b1) begin n_fail++; $display("FAIL arst_s1 got=%b/%h/%0d/%b exp=0/%h/0/1", ov1, od1, occ1, ir1, BUB); end
        n_checks++; if (ov0 !== 1'b0 || od0 !== BUB || occ0 !== 2'd0) begin n_fail++; $display("FAIL arst_s0 got=%b/%h/%0d exp=0/%h/0", ov0, od0, occ0, BUB); end
        #2 Reset_n = 1'b1;
        tick();
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB) begin n_fail++; $display("FAIL arst_stays_empty got=%b/%h exp=0/%h", ov1, od1, BUB); end
        iv1 = 1; id1 = 32'h11; or1 = 1;
        tick();
        iv1 = 0;
        n_checks++; if (ov1 !== 1'b1 || od1 !== 32'h11 || occ1 !== 2'd1) begin n_fail++; $display("FAIL arst_resume got=%b/%h/%0d exp=1/%h/1", ov1, od1, occ1, 32'h11); end
        tick();
        n_checks++; if (ov1 !== 1'b0 || od1 !== BUB) begin n_fail++; $display("FAIL arst_resume_drain got=%b/%h exp=0/%h", ov1, od1, BUB); end
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_noskid();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, self-contained pipeline stage register. It replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic block. It carries a WIDTH-bit payload (control plus data fields packed by the caller) with a valid/ready handshake, synchronous flush-to-bubble and optional one-entry skid buffer. Stalls become backpressure (out_ready low), not a separate protect input.

Parameters:
WIDTH, 32, payload width in bits (>=1)
SKID, 1, 1 = two-entry skid stage with registered in_ready; 0 = single entry with combinational in_ready
BUBBLE, {WIDTH{1'b0}}, payload value presented on out_data when the stage holds no valid entry (NOP encoding)

Ports:
CLK  input  1  clock, rising edge
Reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries and of this cycle's input
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept a payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage presents a valid payload
out_ready  input  1  downstream accepts payload this cycle (0 = stall)
out_data  output  WIDTH  payload; equals BUBBLE when out_valid=0
occupancy  output  2  entries held: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- One clock domain. Reset is asynchronous and active-low: CLK and Reset_n. Reset_n low -> state EMPTY, main/skid regs = BUBBLE, out_valid=0, occupancy=0; in_ready=1 immediately after reset.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency 1 cycle, in_fire to out_valid, when the stage is EMPTY.
- SKID=1 states (out_data always from main reg):
  EMPTY: out_valid=0, in_ready=1. in_fire -> FULL, main<=in_data.
  FULL: out_valid=1, in_ready=1. in_fire&out_fire -> FULL, main<=in_data. in_fire&~out_fire -> SKID, skid<=in_data. ~in_fire&out_fire -> EMPTY, main<=BUBBLE. Otherwise hold.
  SKID: out_valid=1, in_ready=0. out_fire -> FULL, main<=skid, skid<=BUBBLE. Otherwise hold.
- in_ready for SKID=1 is a pure function of registered state. There is no combinational path from out_ready to in_ready.
- SKID=0: states EMPTY/FULL only. in_ready = ~out_valid | out_ready (combinational). FULL with in_fire&out_fire reloads main. Occupancy never exceeds 1.
- Ordering is strict FIFO. The skid entry is never presented before the main entry.
- flush=1 (sync, highest priority): next state EMPTY, main and skid <= BUBBLE, occupancy 0. A concurrent in_fire is accepted by the handshake but its payload is discarded. A concurrent out_fire still counts as consumed downstream. in_ready and out_valid are not gated by flush in the flush cycle.
- Flush and in_valid asserted together with the stage EMPTY -> stage remains EMPTY next cycle.
- Holding a payload: while out_valid=1 and out_ready=0, out_data and out_valid are stable. This holds across any number of cycles.
- Reset asserted mid-transfer aborts everything asynchronously. No partial payload survives.
- No payload arithmetic. Data is moved bit-exact. occupancy encodes EMPTY=0, FULL=1, SKID=2.

Decomposition:
- Shared package pipe_pkg: state encoding localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2, and a default NOP bubble constant.
- Per-stage field packing/unpacking (e.g. PC, ALU control, register addresses) stays in the instantiating stage, not in this block.
- No sub-module required. The skid register is a SKID-gated generate branch inside pipe_stage_reg.

Test Plan:
1. Reset, then in_valid=1 with in_data=0x00000001..0x00000004 on consecutive cycles and out_ready=1 -> out_data 1,2,3,4 one cycle later each. out_valid continuous, occupancy=1.
2. SKID=1, stage FULL with 0xA, out_ready=0, in_data=0xB valid -> occupancy=2, in_ready=0 next cycle, out_data holds 0xA. Raise out_ready -> 0xA then 0xB. No loss, no duplicate.
3. SKID=1, occupancy=2 (0xA, 0xB), flush=1 for one cycle with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0. 0xC never appears at the output.
4. SKID=0, FULL with 0x5, out_ready toggles 0,1 while in_valid=1 -> in_ready follows out_ready in the same cycle. Every accepted word appears exactly once, in order.
5. Random in_valid/out_ready over 10k cycles, both SKID values, scoreboard compare -> output sequence equals accepted input sequence. out_data is stable whenever out_valid&~out_ready.
6. Reset_n pulsed low between clock edges while occupancy=2 -> outputs go to reset values immediately, without waiting for the next clock edge. Operation resumes cleanly after Reset_n rises.
